// File: rtl/line_sensor_adc.sv
// line_sensor_adc: scans left/centre/right line sensors through an ADC128S022-style SPI ADC and
// thresholds them into line_bits. Define LINE_SENSOR_HYST_EN for a per-channel Schmitt compare.
module line_sensor_adc #(
  parameter int unsigned CLK_DIV   = 10,
  parameter int unsigned THRESHOLD = 1500,
  parameter int unsigned HYST      = 100,
  parameter logic [2:0]  CH_LEFT   = 3'd2,
  parameter logic [2:0]  CH_CENTER = 3'd1,
  parameter logic [2:0]  CH_RIGHT  = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [2:0]  line_bits,
  output logic        line_valid,
  output logic [11:0] raw_left,
  output logic [11:0] raw_center,
  output logic [11:0] raw_right
);

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DIV_W   = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);

  if (CLK_DIV < 2 || THRESHOLD > 4095 || HYST > 4095) begin : g_param_check
    $error("line_sensor_adc: illegal CLK_DIV/THRESHOLD/HYST");
  end

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, GAP} state_t;
  typedef enum logic [1:0] {CH_L, CH_C, CH_R} chan_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt, div_next;
  logic [4:0]         half_cnt, half_next;
  logic               sample_c, shift_end_c;
  logic               cs_n_c, sck_c, din_c;
  logic [2:0]         cur_addr_c;
  logic [FRAME_W-1:0] frame_c;

  chan_t              cur_ch, res_ch;
  logic               warm;
  logic [DATA_W-1:0]  shift_q;

`ifdef LINE_SENSOR_HYST_EN
  localparam logic [12:0] HI_LVL = 13'(THRESHOLD + HYST);
  localparam logic        LO_EN  = (THRESHOLD >= HYST);
  localparam logic [12:0] LO_LVL = 13'(LO_EN ? THRESHOLD - HYST : 0);

  function automatic logic compare(input logic [DATA_W-1:0] v, input logic prev);
    if ({1'b0, v} > HI_LVL) return 1'b1;
    if (LO_EN && ({1'b0, v} < LO_LVL)) return 1'b0;
    return prev;
  endfunction
`else
  localparam logic [DATA_W-1:0] TH_LVL = DATA_W'(THRESHOLD);

  function automatic logic compare(input logic [DATA_W-1:0] v);
    return v > TH_LVL;
  endfunction
`endif

  // State and frame-timing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      half_cnt <= half_next;
    end
  end

  // Next state: half_cnt walks the 32 SCK half-periods; odd halves are SCK high
  always_comb begin
    state_next  = state;
    div_next    = div_cnt;
    half_next   = half_cnt;
    sample_c    = 1'b0;
    shift_end_c = 1'b0;
    case (state)
      IDLE: begin
        state_next = CS_SETUP;
        div_next   = '0;
        half_next  = '0;
      end
      CS_SETUP: begin
        if (div_cnt == HALF_LAST) begin
          state_next = SHIFT;
          div_next   = '0;
          half_next  = '0;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        sample_c = half_cnt[0] && (div_cnt == '0);
        if (div_cnt == HALF_LAST) begin
          div_next = '0;
          if (half_cnt == 5'd31) begin
            state_next  = GAP;
            shift_end_c = 1'b1;
          end else begin
            half_next = half_cnt + 5'd1;
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_cnt == GAP_LAST) begin
          state_next = CS_SETUP;
          div_next   = '0;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (cur_ch)
      CH_L:    cur_addr_c = CH_LEFT;
      CH_C:    cur_addr_c = CH_CENTER;
      default: cur_addr_c = CH_RIGHT;
    endcase
  end

  // Serial pin values; din follows SCK falling edges MSB first
  always_comb begin
    frame_c = FRAME_W'(cur_addr_c) << 11;
    cs_n_c  = 1'b1;
    sck_c   = 1'b1;
    din_c   = 1'b0;
    case (state)
      CS_SETUP: begin
        cs_n_c = 1'b0;
        din_c  = frame_c[15];
      end
      SHIFT: begin
        cs_n_c = 1'b0;
        sck_c  = half_cnt[0];
        din_c  = frame_c[4'd15 - half_cnt[4:1]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sck  <= 1'b1;
      adc_din  <= 1'b0;
    end else begin
      adc_cs_n <= cs_n_c;
      adc_sck  <= sck_c;
      adc_din  <= din_c;
    end
  end

  // Capture, result routing and threshold; a frame returns the previous frame's channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      raw_left   <= '0;
      raw_center <= '0;
      raw_right  <= '0;
      line_bits  <= 3'b000;
      line_valid <= 1'b0;
      cur_ch     <= CH_L;
      res_ch     <= CH_L;
      warm       <= 1'b1;
    end else begin
      line_valid <= 1'b0;
      if (sample_c && (half_cnt[4:1] >= 4'd4)) begin
        shift_q <= {shift_q[DATA_W-2:0], adc_dout};
      end
      if (shift_end_c) begin
        if (!warm) begin
          case (res_ch)
            CH_L: raw_left   <= shift_q;
            CH_C: raw_center <= shift_q;
            default: begin
              raw_right  <= shift_q;
              line_valid <= 1'b1;
`ifdef LINE_SENSOR_HYST_EN
              line_bits  <= {compare(raw_left, line_bits[2]), compare(raw_center, line_bits[1]),
                             compare(shift_q, line_bits[0])};
`else
              line_bits  <= {compare(raw_left), compare(raw_center), compare(shift_q)};
`endif
            end
          endcase
        end
        warm   <= 1'b0;
        res_ch <= cur_ch;
        case (cur_ch)
          CH_L:    cur_ch <= CH_C;
          CH_C:    cur_ch <= CH_R;
          default: cur_ch <= CH_L;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_sensor_adc.sv
// Scoreboard bench for line_sensor_adc: an ADC model answers each request one frame late and
// predicts the thresholded triple; a monitor compares it whenever line_valid pulses.
module tb_line_sensor_adc;

  localparam int CD        = 10;
  localparam int TH        = 1500;
  localparam int HY        = 100;
  localparam int FRAME     = 35 * CD;
  localparam int PULSE_GAP = 105 * CD;
  localparam int A_L       = 2;
  localparam int A_C       = 1;
  localparam int A_R       = 0;

  typedef struct packed {
    logic [2:0]  bits;
    logic [11:0] l;
    logic [11:0] c;
    logic [11:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sck, adc_din, line_valid;
  logic [2:0]  line_bits;
  logic [11:0] raw_left, raw_center, raw_right;

  line_sensor_adc #(.CLK_DIV(CD), .THRESHOLD(TH), .HYST(HY)) dut (
    .clk(clk), .rst_n(rst_n), .adc_dout(adc_dout), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck),
    .adc_din(adc_din), .line_bits(line_bits), .line_valid(line_valid), .raw_left(raw_left),
    .raw_center(raw_center), .raw_right(raw_right)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  exp_t q[$];
  int   dir_tbl [6][3] = '{'{2000, 1000, 1500}, '{'hA00, 'h0B0, 'h00C}, '{1501, 1650, 1500},
                           '{1500, 1550, 1501}, '{4095, 1450, 0}, '{0, 1350, 4095}};
  int   exp_addr [3] = '{A_L, A_C, A_R};

  function automatic logic [11:0] pick(input int t, input int ch);
    int r;
    if (t < 6) return 12'(dir_tbl[t][ch]);
    r = int'($urandom_range(0, 3));
    if (r == 0) return 12'($urandom_range(0, 4095));
    return 12'(TH - 2 + int'($urandom_range(0, 4)));
  endfunction

  // ADC model, sampled mid-cycle so every pin seen has settled
  logic        sck_d, cs_d, per_ok;
  int          nbits, falls, frames, triple, mcyc, last_rise, cs_rise_cyc, cs_fall_cyc, addr;
  logic [15:0] din_sr, dout_word;
  logic [11:0] next_val, cur_l, cur_c, v;
  logic [2:0]  hb;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sck_d = 1'b1; cs_d = 1'b1; nbits = 0; falls = 0; din_sr = '0; frames = 0; triple = 0;
      next_val = 12'hFFF; adc_dout = 1'b0; hb = 3'b000; per_ok = 1'b1; cs_rise_cyc = -1;
      last_rise = -1; mcyc = 0; cur_l = '0; cur_c = '0;
      q.delete();
    end else begin
      mcyc++;
      if (cs_d && !adc_cs_n) begin
        if (cs_rise_cyc >= 0) check("cs_high_cycles", mcyc - cs_rise_cyc, 2 * CD);
        cs_fall_cyc = mcyc; nbits = 0; falls = 0; din_sr = '0; per_ok = 1'b1; last_rise = -1;
        dout_word = {4'b0000, next_val};
        adc_dout = 1'b0;
      end
      if (!adc_cs_n && sck_d && !adc_sck) begin
        if (falls == 0) check("cs_setup_cycles", mcyc - cs_fall_cyc, CD);
        if (falls < 16) adc_dout = dout_word[15 - falls];
        falls++;
      end
      if (!adc_cs_n && !sck_d && adc_sck) begin
        if (last_rise >= 0 && (mcyc - last_rise) != 2 * CD) per_ok = 1'b0;
        last_rise = mcyc;
        din_sr = {din_sr[14:0], adc_din};
        nbits++;
      end
      if (!cs_d && adc_cs_n) begin
        cs_rise_cyc = mcyc;
        check("sck_pulses", nbits, 16);
        check("sck_period_ok", int'(per_ok), 1);
        if (nbits == 16) begin
          addr = int'(din_sr[13:11]);
          check("din_addr", addr, exp_addr[frames % 3]);
          check("din_zero_bits", int'(din_sr & 16'hC7FF), 0);
          v = 12'h000;
          if (addr == A_L) begin
            v = pick(triple, 0); cur_l = v;
          end else if (addr == A_C) begin
            v = pick(triple, 1); cur_c = v;
          end else if (addr == A_R) begin
            v = pick(triple, 2);
`ifdef LINE_SENSOR_HYST_EN
            if (int'(cur_l) > TH + HY) hb[2] = 1'b1; else if (int'(cur_l) < TH - HY) hb[2] = 1'b0;
            if (int'(cur_c) > TH + HY) hb[1] = 1'b1; else if (int'(cur_c) < TH - HY) hb[1] = 1'b0;
            if (int'(v) > TH + HY) hb[0] = 1'b1; else if (int'(v) < TH - HY) hb[0] = 1'b0;
`else
            hb = {int'(cur_l) > TH, int'(cur_c) > TH, int'(v) > TH};
`endif
            e.bits = hb; e.l = cur_l; e.c = cur_c; e.r = v;
            q.push_back(e);
            triple++;
          end
          next_val = v;
          frames++;
        end
      end
      sck_d = adc_sck;
      cs_d  = adc_cs_n;
    end
  end

  // Monitor: pops one expected triple per line_valid pulse
  int         cyc = 0, last_valid_cyc = 0, valids = 0;
  logic       first = 1'b1;
  logic [2:0] held = 3'b000, lb_prev = 3'b000;
  exp_t       got;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc = 0; first = 1'b1; held = 3'b000;
    end else begin
      cyc++;
      if (line_valid) begin
        valids++;
        check("bits_held", int'(lb_prev), int'(held));
        if (first) begin
          total++;
          if (cyc >= 3 * FRAME && cyc <= 4 * FRAME) passed++;
          else $display("FAIL first_valid_cycle: got %0d required within %0d..%0d", cyc, 3 * FRAME, 4 * FRAME);
        end else begin
          check("valid_period", cyc - last_valid_cyc, PULSE_GAP);
        end
        first = 1'b0;
        last_valid_cyc = cyc;
        if (q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_empty: line_valid at cycle %0d with no expected result", cyc);
        end else begin
          got = q.pop_front();
          check("line_bits", int'(line_bits), int'(got.bits));
          check("raw_left", int'(raw_left), int'(got.l));
          check("raw_center", int'(raw_center), int'(got.c));
          check("raw_right", int'(raw_right), int'(got.r));
          held = got.bits;
        end
      end
      lb_prev = line_bits;
    end
  end

  task automatic wait_valids(input int n);
    int target = valids + n;
    int budget = n * PULSE_GAP + 4 * FRAME;
    for (int i = 0; i < budget && valids < target; i++) @(posedge clk);
    #2;
    if (valids < target) begin
      total++;
      $display("FAIL valid_timeout: got %0d pulses required %0d", valids, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, int'(adc_cs_n), 1);
    check({tag, "_sck"}, int'(adc_sck), 1);
    check({tag, "_line_bits"}, int'(line_bits), 0);
    check({tag, "_line_valid"}, int'(line_valid), 0);
    check({tag, "_raw_left"}, int'(raw_left), 0);
    check({tag, "_raw_right"}, int'(raw_right), 0);
  endtask

  initial begin
    int i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_din", int'(adc_din), 0);
    check("rst_raw_center", int'(raw_center), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1 check("cs_n_edge1", int'(adc_cs_n), 1);
    @(posedge clk) #1 check("cs_n_edge2", int'(adc_cs_n), 0);
    repeat (298) @(posedge clk);
    #1;
    check("frame0_line_bits", int'(line_bits), 0);
    check("frame0_raw_left", int'(raw_left), 0);
    check("frame0_raw_right", int'(raw_right), 0);
    repeat (600) @(posedge clk);
    #1;
    check("no_early_valid", valids, 0);
    wait_valids(10);

    // Abort in the middle of SHIFT period 7
    i = 0;
    while (i < 4 * FRAME && !(nbits == 8 && !adc_cs_n)) begin
      @(posedge clk);
      i++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_valids(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
